// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage between execute and write-back.
//            Captures the EX result into a single stage register, performs
//            loads/stores over a ready-handshaked data-memory port (stalling
//            EX while the memory is busy), extends load data and drives the
//            registered bundle consumed by write-back.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            es_*                  - instruction presented by EX
//            ms_stall              - EX must hold its outputs this cycle
//            dm_*                  - data-memory request / response port
//            ms_mem_out, ms_alu_result, ms_ctrl, ms_rd - registered WB bundle
//            ms_mem_err            - one-cycle pulse for a dropped access
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            es_valid,
    input  logic [XLEN-1:0] es_alu_result,
    input  logic [XLEN-1:0] es_rs2_data,
    input  logic [5:0]      es_ctrl,
    input  logic [2:0]      es_funct3,
    input  logic [4:0]      es_rd,
    output logic            ms_stall,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [3:0]      dm_be,
    output logic [XLEN-1:0] dm_wdata,
    input  logic            dm_ready,
    input  logic [XLEN-1:0] dm_rdata,
    output logic [XLEN-1:0] ms_mem_out,
    output logic [XLEN-1:0] ms_alu_result,
    output logic [5:0]      ms_ctrl,
    output logic [4:0]      ms_rd,
    output logic            ms_mem_err
);

    // FSM encoding
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Bits [5:4] of ctrl survive a dropped access; reg_wen/mem2reg do not.
    localparam logic [5:0] c_ERR_CTRL_MASK = 6'b110000;

    // Access size encoding held in funct3[1:0]
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;
    localparam logic [1:0] c_SZ_W = 2'b10;

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    logic            r_valid;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [5:0]      r_ctrl;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic [0:0]      r_state;

    logic            w_is_mem;
    logic            w_illegal;
    logic            w_misalign;
    logic            w_err;
    logic            w_mem_op;
    logic            w_done;
    logic            w_allowin;
    logic [1:0]      w_off;
    logic [1:0]      w_size;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_ext;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_lane;

    assign w_off  = r_addr[1:0];
    assign w_size = r_funct3[1:0];

    assign w_is_mem  = r_valid & (r_ctrl[2] | r_ctrl[3]);
    assign w_illegal = (r_funct3 == 3'b011) | (r_funct3 == 3'b110) |
                       (r_funct3 == 3'b111);
    assign w_misalign = ((w_size == c_SZ_H) & w_off[0]) |
                        ((w_size == c_SZ_W) & (w_off != 2'b00));
    assign w_err     = w_is_mem & (w_illegal | w_misalign);
    assign w_mem_op  = w_is_mem & ~w_err;
    assign w_done    = r_valid & (~w_mem_op | dm_ready);
    assign w_allowin = ~r_valid | w_done;
    assign ms_stall  = r_valid & ~w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ctrl   <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
        end else if (w_allowin) begin
            // Back-to-back: a new instruction may enter on the same edge
            // the current one completes.
            r_valid <= es_valid;
            if (es_valid) begin
                r_addr   <= es_alu_result;
                r_wdata  <= es_rs2_data;
                r_ctrl   <= es_ctrl;
                r_funct3 <= es_funct3;
                r_rd     <= es_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM. The request and its payload come straight from the
    // stage register, which is frozen while stalled, so they stay stable
    // for the whole WAIT period and vanish as soon as reset clears r_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_mem_op && !dm_ready) r_state <= S_WAIT;
                S_WAIT: if (dm_ready)              r_state <= S_IDLE;
                default:                           r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store lane steering
    // ------------------------------------------------------------------
    always_comb begin
        w_be         = 4'b1111;
        w_wdata_lane = r_wdata;
        case (w_size)
            c_SZ_B: begin
                w_be         = 4'b0001 << w_off;
                w_wdata_lane = {4{r_wdata[7:0]}};
            end
            c_SZ_H: begin
                w_be         = 4'b0011 << w_off;
                w_wdata_lane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be         = 4'b1111;
                w_wdata_lane = r_wdata;
            end
        endcase
    end

    assign dm_req   = w_mem_op;
    assign dm_we    = w_mem_op & r_ctrl[3];
    assign dm_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign dm_be    = (w_mem_op & r_ctrl[3]) ? w_be : 4'b0000;
    assign dm_wdata = w_wdata_lane;

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = dm_rdata[7:0];
        case (w_off)
            2'd0: w_byte = dm_rdata[7:0];
            2'd1: w_byte = dm_rdata[15:8];
            2'd2: w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
    end

    assign w_half = w_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        w_load_ext = dm_rdata;
        case (r_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_ext = dm_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-back bundle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_mem_out    <= '0;
            ms_alu_result <= '0;
            ms_ctrl       <= '0;
            ms_rd         <= '0;
            ms_mem_err    <= 1'b0;
        end else if (w_done) begin
            ms_alu_result <= r_addr;
            ms_rd         <= r_rd;
            if (w_err) begin
                // Dropped access: no register write, no memory data.
                ms_ctrl    <= r_ctrl & c_ERR_CTRL_MASK;
                ms_mem_err <= 1'b1;
                ms_mem_out <= '0;
            end else begin
                ms_ctrl    <= r_ctrl;
                ms_mem_err <= 1'b0;
                ms_mem_out <= r_ctrl[2] ? w_load_ext : '0;
            end
        end else begin
            // Bubble: WB sees no write; data fields hold.
            ms_ctrl    <= '0;
            ms_mem_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage with hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        es_valid;
    logic [31:0] es_alu_result;
    logic [31:0] es_rs2_data;
    logic [5:0]  es_ctrl;
    logic [2:0]  es_funct3;
    logic [4:0]  es_rd;
    logic        ms_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic [31:0] ms_mem_out;
    logic [31:0] ms_alu_result;
    logic [5:0]  ms_ctrl;
    logic [4:0]  ms_rd;
    logic        ms_mem_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.XLEN(32)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .es_valid      (es_valid),
        .es_alu_result (es_alu_result),
        .es_rs2_data   (es_rs2_data),
        .es_ctrl       (es_ctrl),
        .es_funct3     (es_funct3),
        .es_rd         (es_rd),
        .ms_stall      (ms_stall),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_be         (dm_be),
        .dm_wdata      (dm_wdata),
        .dm_ready      (dm_ready),
        .dm_rdata      (dm_rdata),
        .ms_mem_out    (ms_mem_out),
        .ms_alu_result (ms_alu_result),
        .ms_ctrl       (ms_ctrl),
        .ms_rd         (ms_rd),
        .ms_mem_err    (ms_mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, capture it into the stage register, then
    // withdraw es_valid (only safe when the stage can accept).
    task automatic issue(input logic [5:0] ctrl, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [2:0] f3,
                         input logic [4:0] rd);
        es_valid      = 1'b1;
        es_ctrl       = ctrl;
        es_alu_result = alu;
        es_rs2_data   = rs2;
        es_funct3     = f3;
        es_rd         = rd;
        tick();
        es_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; es_valid = 1'b0; es_alu_result = '0; es_rs2_data = '0;
        es_ctrl = '0; es_funct3 = '0; es_rd = '0; dm_ready = 1'b0;
        dm_rdata = '0;
        tick(); tick();
        check("rst_ctrl",  {26'd0, ms_ctrl}, 32'd0);
        check("rst_stall", {31'd0, ms_stall}, 32'd0);
        check("rst_req",   {31'd0, dm_req}, 32'd0);
        check("rst_alu",   ms_alu_result, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- ALU op passes through, no memory request
        issue(6'b000001, 32'h0000_1234, 32'h0, 3'b000, 5'd5);
        check("alu_req", {31'd0, dm_req}, 32'd0);
        tick();
        check("alu_ctrl", {26'd0, ms_ctrl}, 32'h01);
        check("alu_res",  ms_alu_result, 32'h0000_1234);
        check("alu_rd",   {27'd0, ms_rd}, 32'd5);
        tick();
        check("alu_bubble_ctrl", {26'd0, ms_ctrl}, 32'd0);
        check("alu_bubble_hold", ms_alu_result, 32'h0000_1234);

        // ---- LB / LBU at byte offset 3
        dm_ready = 1'b1;
        dm_rdata = 32'h80FF_0000;
        issue(6'b000111, 32'h0000_0103, 32'h0, 3'b000, 5'd6);
        check("lb_req",  {31'd0, dm_req}, 32'd1);
        check("lb_addr", dm_addr, 32'h0000_0100);
        check("lb_be",   {28'd0, dm_be}, 32'd0);
        check("lb_we",   {31'd0, dm_we}, 32'd0);
        tick();
        check("lb_out", ms_mem_out, 32'hFFFF_FF80);
        issue(6'b000111, 32'h0000_0103, 32'h0, 3'b100, 5'd6);
        tick();
        check("lbu_out", ms_mem_out, 32'h0000_0080);

        // ---- LH / LHU at upper half
        dm_rdata = 32'h8001_7FFF;
        issue(6'b000111, 32'h0000_0102, 32'h0, 3'b001, 5'd8);
        tick();
        check("lh_out", ms_mem_out, 32'hFFFF_8001);
        issue(6'b000111, 32'h0000_0100, 32'h0, 3'b101, 5'd8);
        tick();
        check("lhu_low_out", ms_mem_out, 32'h0000_7FFF);

        // ---- SH / SB lane steering
        issue(6'b001000, 32'h0000_0202, 32'hABCD_1234, 3'b001, 5'd0);
        check("sh_we",    {31'd0, dm_we}, 32'd1);
        check("sh_addr",  dm_addr, 32'h0000_0200);
        check("sh_be",    {28'd0, dm_be}, 32'b1100);
        check("sh_wdata", dm_wdata, 32'h1234_1234);
        tick();
        check("sh_ctrl", {26'd0, ms_ctrl}, 32'b001000);
        issue(6'b001000, 32'h0000_0201, 32'h1234_5678, 3'b000, 5'd0);
        check("sb_be",    {28'd0, dm_be}, 32'b0010);
        check("sb_wdata", dm_wdata, 32'h7878_7878);
        tick();

        // ---- LW with 3 wait cycles, EX holding a second LW meanwhile
        dm_ready = 1'b0;
        issue(6'b000111, 32'h0000_0040, 32'h0, 3'b010, 5'd9);
        es_valid = 1'b1; es_ctrl = 6'b000111; es_alu_result = 32'h0000_0044;
        es_funct3 = 3'b010; es_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wait_stall%0d", i), {31'd0, ms_stall}, 32'd1);
            check($sformatf("wait_req%0d", i),   {31'd0, dm_req}, 32'd1);
            check($sformatf("wait_addr%0d", i),  dm_addr, 32'h0000_0040);
            check($sformatf("wait_ctrl%0d", i),  {26'd0, ms_ctrl}, 32'd0);
            tick();
        end
        dm_ready = 1'b1;
        dm_rdata = 32'h1111_2222;
        #1;
        check("wait_release_stall", {31'd0, ms_stall}, 32'd0);
        tick();
        es_valid = 1'b0;
        check("lw1_out",  ms_mem_out, 32'h1111_2222);
        check("lw1_rd",   {27'd0, ms_rd}, 32'd9);
        check("lw1_ctrl", {26'd0, ms_ctrl}, 32'b000111);
        check("lw2_addr", dm_addr, 32'h0000_0044);
        dm_rdata = 32'h3333_4444;
        tick();
        check("lw2_out",  ms_mem_out, 32'h3333_4444);
        check("lw2_rd",   {27'd0, ms_rd}, 32'd7);
        check("lw2_ctrl", {26'd0, ms_ctrl}, 32'b000111);

        // ---- Misaligned LW: dropped with a one-cycle error pulse
        dm_ready = 1'b0;
        issue(6'b110111, 32'h0000_0006, 32'h0, 3'b010, 5'd3);
        check("err_req",   {31'd0, dm_req}, 32'd0);
        check("err_stall", {31'd0, ms_stall}, 32'd0);
        tick();
        check("err_pulse", {31'd0, ms_mem_err}, 32'd1);
        check("err_ctrl",  {26'd0, ms_ctrl}, 32'b110000);
        tick();
        check("err_pulse_end", {31'd0, ms_mem_err}, 32'd0);

        // ---- Reset during WAIT
        issue(6'b000111, 32'h0000_0080, 32'h0, 3'b010, 5'd4);
        tick();
        check("pre_rst_req", {31'd0, dm_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",   {31'd0, dm_req}, 32'd0);
        check("mid_rst_stall", {31'd0, ms_stall}, 32'd0);
        check("mid_rst_alu",   ms_alu_result, 32'd0);
        check("mid_rst_rd",    {27'd0, ms_rd}, 32'd0);
        check("mid_rst_addr",  dm_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        dm_ready = 1'b1;
        tick();
        issue(6'b001000, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 5'd0);
        check("sw_req",   {31'd0, dm_req}, 32'd1);
        check("sw_we",    {31'd0, dm_we}, 32'd1);
        check("sw_addr",  dm_addr, 32'h0000_0010);
        check("sw_be",    {28'd0, dm_be}, 32'b1111);
        check("sw_wdata", dm_wdata, 32'hDEAD_BEEF);
        tick();
        check("sw_ctrl", {26'd0, ms_ctrl}, 32'b001000);
        check("sw_alu",  ms_alu_result, 32'h0000_0010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between execute (EX) and write-back (WB).
- Registers the EX result and performs loads/stores on a ready-handshaked data-memory port, stalling EX while memory is busy.
- Sign/zero-extends load data.
- Drives the registered ms_mem_out / ms_alu_result / ms_ctrl / ms_rd bundle that WB consumes (ms_ctrl[1] = mem2reg select, ms_ctrl[0] = reg write enable).

Parameters:
- XLEN, 32, datapath/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- es_valid  in  1  EX presents a valid instruction this cycle
- es_alu_result  in  32  ALU result; effective address for loads/stores
- es_rs2_data  in  32  store data
- es_ctrl  in  6  [0] reg_wen, [1] mem2reg, [2] mem_read, [3] mem_write, [5:4] passed through untouched
- es_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- es_rd  in  5  destination register
- ms_stall  out  1  EX must hold its outputs this cycle
- dm_req  out  1  memory request
- dm_we  out  1  1 = store
- dm_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dm_be  out  4  byte enables (stores; 4'b0000 on loads)
- dm_wdata  out  32  lane-replicated store data
- dm_ready  in  1  access completes this cycle; read data valid
- dm_rdata  in  32  read word
- ms_mem_out  out  32  extended load data to WB
- ms_alu_result  out  32  ALU result to WB
- ms_ctrl  out  6  control to WB
- ms_rd  out  5  destination to WB
- ms_mem_err  out  1  one-cycle pulse: misaligned or illegal-size access dropped

Behaviour:
- Internal stage register R holds {valid, addr, wdata, ctrl, funct3, rd}.
- R loads when ms_allowin = !R.valid | done, and is cleared to valid=0 when done with no es_valid.
- ms_stall = R.valid & !done.
- mem_op = R.valid & (ctrl[2] | ctrl[3]) & !err.
- err = R.valid & (ctrl[2] | ctrl[3]) & (illegal funct3 (011, 110, 111) | H with addr[0] = 1 | W with addr[1:0] != 0).
- done = R.valid & (!mem_op | dm_ready).
- FSM states:
  - IDLE: dm_req = mem_op. If dm_ready, complete; else go to WAIT.
  - WAIT: dm_req held at 1 with dm_addr / dm_we / dm_be / dm_wdata stable. On dm_ready, complete and return to IDLE.
  - A new instruction can enter R on the same edge the previous one completes, giving back-to-back accesses with no bubble.
- Completion edge:
  - ms_alu_result <= addr; ms_rd <= rd; ms_ctrl <= ctrl.
  - ms_mem_out <= extended load data when ctrl[2], else 0.
  - On err: ms_ctrl <= ctrl & 6'b110000 (kills reg_wen and mem2reg) and ms_mem_err <= 1.
- Non-completion edge (bubble): ms_ctrl <= 0, ms_mem_err <= 0. Other outputs hold their value.
- Latency: an instruction captured into R at edge N appears on the WB outputs at edge N+1+k, where k = number of wait cycles.
- Load extraction, with byte offset o = addr[1:0]:
  - B / BU: byte dm_rdata[8o+7:8o], sign- or zero-extended.
  - H / HU: half dm_rdata[16*o[1]+15:16*o[1]], sign- or zero-extended.
  - W: full word.
- Store lanes:
  - SB: be = 4'b0001 << o; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << o; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
- An err access never asserts dm_req and completes in one cycle.
- Reset (async, mid-access included):
  - R.valid = 0, FSM = IDLE, all outputs 0.
  - dm_req drops immediately on rst_n low.
  - An in-flight access is abandoned; memory must tolerate a request withdrawn without a ready.
- If es_valid is presented while ms_stall = 1, it is ignored (not captured); EX must hold.

Test Plan:
1. ALU op (ctrl=6'b000001, alu=32'h0000_1234, rd=5) -> one cycle later ms_ctrl=6'b000001, ms_alu_result=32'h1234, ms_rd=5, dm_req never asserts.
2. LB at addr 32'h103 with dm_rdata=32'h80FF_0000, dm_ready tied 1 -> ms_mem_out=32'hFFFF_FF80. The same access as LBU -> 32'h0000_0080.
3. SH at addr 32'h202, rs2=32'hABCD_1234 -> dm_we=1, dm_addr=32'h200, dm_be=4'b1100, dm_wdata=32'h1234_1234.
4. LW with dm_ready low for 3 cycles -> ms_stall high exactly 3 cycles; dm_req/dm_addr stable throughout; ms_ctrl=0 during the wait; a back-to-back LW completes on the next cycle without a bubble.
5. LW at addr 32'h6 -> no dm_req; ms_mem_err pulses 1 cycle; ms_ctrl[1:0]=0.
6. Assert rst_n low during WAIT -> dm_req=0 immediately, all outputs 0. After release, a new SW issues normally.
